// File: rtl/keycode_pkg.sv
// Shared constants and types for the PS/2 keycode source: HID usage codes,
// PS/2 Set-2 prefix bytes, the framer state encoding and the scan-code map.
package keycode_pkg;

    // HID usage codes for the supported keys
    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_SPACE = 8'd44;
    localparam logic [7:0] KEY_ESC   = 8'd41;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;

    // PS/2 Set-2 prefix bytes
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Framer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    // Translate {extended flag, scan code} into a HID usage; KEY_NONE if unmapped
    function automatic logic [7:0] ps2_to_hid(input logic ext, input logic [7:0] code);
        logic [7:0] hid;
        case ({ext, code})
            9'h029:  hid = KEY_SPACE;
            9'h076:  hid = KEY_ESC;
            9'h05A:  hid = KEY_ENTER;
            9'h01D:  hid = KEY_W;
            9'h01C:  hid = KEY_A;
            9'h01B:  hid = KEY_S;
            9'h023:  hid = KEY_D;
            9'h175:  hid = KEY_UP;
            9'h172:  hid = KEY_DOWN;
            9'h16B:  hid = KEY_LEFT;
            9'h174:  hid = KEY_RIGHT;
            default: hid = KEY_NONE;
        endcase
        return hid;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 receive path: synchronizers, ps2_clk glitch filter, 11-bit framer
// with timeout. Emits one-cycle byte_valid or frame_err pulses (never both).
// Optional parity enforcement: define PS2_PARITY_CHECK_EN.
module ps2_frame_rx
    import keycode_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    // Bit 0 carries ps2_data, bit 1 carries ps2_clk
    logic [1:0] raw_in;
    logic [1:0] sync1_reg;
    logic [1:0] sync2_reg;

    assign raw_in = {ps2_clk, ps2_data};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            // Two-flop synchronizer; resets to the idle-high bus level
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg[gi] <= 1'b1;
                    sync2_reg[gi] <= 1'b1;
                end else begin
                    sync1_reg[gi] <= raw_in[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate

    logic             sync_data;
    logic             sync_clk;
    logic             filt_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             flip;
    logic             fall_reg;
    logic             data_smp_reg;

    assign sync_data = sync2_reg[0];
    assign sync_clk  = sync2_reg[1];
    // Level is accepted on the FILTER_LEN-th consecutive differing sample
    assign flip      = (sync_clk != filt_reg) && (cnt_reg == CNT_W'(FILTER_LEN - 1));

    // Glitch filter on ps2_clk plus registered falling-edge strobe and data sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_reg     <= 1'b1;
            cnt_reg      <= '0;
            fall_reg     <= 1'b0;
            data_smp_reg <= 1'b1;
        end else begin
            if (sync_clk == filt_reg) begin
                cnt_reg <= '0;
            end else if (flip) begin
                filt_reg <= sync_clk;
                cnt_reg  <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            fall_reg     <= flip && filt_reg;
            data_smp_reg <= sync_data;
        end
    end

    frame_state_t     state_reg, state_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic             par_reg, par_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic [7:0]       byte_reg, byte_next;
    logic             valid_reg, valid_next;
    logic             err_reg, err_next;
    logic             timeout;
    logic             parity_ok;

`ifdef PS2_PARITY_CHECK_EN
    // Odd parity over the eight data bits and the parity bit
    assign parity_ok = ^{shift_reg, par_reg};
`else
    assign parity_ok = 1'b1;
`endif

    assign timeout = (state_reg != ST_IDLE) && !fall_reg &&
                     (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));

    // Framer state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            par_reg     <= 1'b0;
            timer_reg   <= '0;
            byte_reg    <= '0;
            valid_reg   <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            par_reg     <= par_next;
            timer_reg   <= timer_next;
            byte_reg    <= byte_next;
            valid_reg   <= valid_next;
            err_reg     <= err_next;
        end
    end

    // Framer next-state: timeout has priority, otherwise advance on each strobe
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        par_next     = par_reg;
        byte_next    = byte_reg;
        valid_next   = 1'b0;
        err_next     = 1'b0;
        timer_next   = (state_reg == ST_IDLE || fall_reg) ? '0 : timer_reg + TMR_W'(1);

        if (timeout) begin
            state_next = ST_IDLE;
            err_next   = 1'b1;
        end else if (fall_reg) begin
            case (state_reg)
                ST_IDLE: begin
                    // A high "start bit" is just noise on an idle bus
                    if (!data_smp_reg) begin
                        state_next   = ST_DATA;
                        bit_cnt_next = '0;
                    end
                end
                ST_DATA: begin
                    shift_next   = {data_smp_reg, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_next   = data_smp_reg;
                    state_next = ST_STOP;
                end
                ST_STOP: begin
                    state_next = ST_IDLE;
                    if (data_smp_reg && parity_ok) begin
                        valid_next = 1'b1;
                        byte_next  = shift_reg;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign rx_byte    = byte_reg;
    assign byte_valid = valid_reg;
    assign frame_err  = err_reg;

endmodule

// File: rtl/ps2_keycode_source.sv
// Keyboard front end: receives PS/2 Set-2 frames, tracks E0/F0 prefixes and
// holds the HID code of the most recently pressed supported key.
// Optional parity enforcement: define PS2_PARITY_CHECK_EN.
module ps2_keycode_source
    import keycode_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] Keycode,
    output logic       key_event,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       byte_valid;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (Clock),
        .rst_n      (Reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    logic       ext_reg, ext_next;
    logic       brk_reg, brk_next;
    logic [7:0] keycode_reg, keycode_next;
    logic       event_reg, event_next;
    logic [7:0] hid;

    assign hid = ps2_to_hid(ext_reg, rx_byte);

    // Prefix flags and held-key register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ext_reg     <= 1'b0;
            brk_reg     <= 1'b0;
            keycode_reg <= KEY_NONE;
            event_reg   <= 1'b0;
        end else begin
            ext_reg     <= ext_next;
            brk_reg     <= brk_next;
            keycode_reg <= keycode_next;
            event_reg   <= event_next;
        end
    end

    // Decode each received byte; newest make wins, break only releases the held key
    always_comb begin
        ext_next     = ext_reg;
        brk_next     = brk_reg;
        keycode_next = keycode_reg;
        event_next   = 1'b0;

        if (byte_valid) begin
            if (rx_byte == PS2_EXT) begin
                ext_next = 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_next = 1'b1;
            end else begin
                ext_next = 1'b0;
                brk_next = 1'b0;
                if (hid != KEY_NONE) begin
                    if (!brk_reg) begin
                        // Typematic repeats of the held key change nothing
                        if (hid != keycode_reg) begin
                            keycode_next = hid;
                            event_next   = 1'b1;
                        end
                    end else if (hid == keycode_reg) begin
                        keycode_next = KEY_NONE;
                        event_next   = 1'b1;
                    end
                end
            end
        end
    end

    assign Keycode   = keycode_reg;
    assign key_event = event_reg;

endmodule

// File: doc/ps2_keycode_source.md
Name: ps2_keycode_source

Overview:
- Keyboard front end that produces the 8-bit Keycode stream consumed by the game-state FSM.
- Receives PS/2 Set-2 scan-code frames from the keyboard pins and decodes E0 (extended) and F0 (break) prefixes.
- Translates the supported keys to USB HID usage codes (space = 8'd44, esc = 8'd41) and holds the code while the key is down.
- Sits between the board PS/2 pins and the state machine / game logic.

Parameters:
- FILTER_LEN, 4: ps2_clk must be stable for this many Clock cycles before a level change is accepted.
- TIMEOUT_CYCLES, 50000: Clock cycles with no accepted ps2_clk falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).

Ports:
- Clock  in  1  system clock; all logic on posedge.
- Reset  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin; asynchronous to Clock.
- ps2_data  in  1  raw PS/2 data pin; asynchronous to Clock.
- Keycode  out  8  HID code of the currently held supported key; 8'h00 when none is held.
- key_event  out  1  one-cycle pulse whenever Keycode changes value.
- frame_err  out  1  one-cycle pulse on a framing, parity or timeout error.

Behaviour:
- Reset (asynchronous assert, synchronous release) forces all outputs to 0, framer to IDLE, prefix flags cleared and filter/timeout counters cleared.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - A filtered clock level changes only after FILTER_LEN consecutive equal samples.
  - A falling edge of the filtered clock is the sample strobe.
  - ps2_data is sampled on that strobe.
- Framer FSM (IDLE, DATA, PARITY, STOP):
  - IDLE: on strobe with data = 0 (start bit), go to DATA with bit count = 0; with data = 1, stay in IDLE and do not flag an error.
  - DATA: shift 8 bits LSB first; after the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: if stop bit = 1 (and parity passes, see the optional feature), issue a byte-valid strobe for one cycle; otherwise pulse frame_err. Return to IDLE in both cases.
  - Timeout: in any non-IDLE state, TIMEOUT_CYCLES without a strobe means go to IDLE, pulse frame_err and discard the partial byte.
- Decoder, acting on each byte strobe:
  - E0: set ext. F0: set brk. Neither byte changes Keycode.
  - Any other byte: look up {ext, byte}, then clear ext and brk in the same cycle.
  - Make (brk = 0), mapped: Keycode <= HID code. The newest key wins.
  - Break (brk = 1), mapped: if the HID code equals the current Keycode, Keycode <= 0; otherwise no change.
  - Unmapped codes (including E1/pause sequences) are ignored, but prefix flags are still cleared.
  - Typematic repeat (a repeated make of the same key) leaves Keycode unchanged and produces no key_event.
- Map (PS/2 to HID): 29 to 2C space; 76 to 29 esc; 5A to 28 enter; 1D to 1A W; 1C to 04 A; 1B to 16 S; 23 to 07 D; E0 75 to 52 up; E0 72 to 51 down; E0 6B to 50 left; E0 74 to 4F right.
- Latency: Keycode updates 1 cycle after the byte strobe, and the strobe occurs 1 cycle after the stop-bit sample. key_event asserts in the same cycle Keycode changes.
- frame_err and a byte strobe never occur in the same cycle.
- This block never drives the PS/2 lines; it is input-only.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: the parity bit must make the 9 bits (data + parity) odd. On mismatch the byte is dropped, frame_err pulses and decoder state is unchanged.
- Undefined: the parity bit is sampled and ignored; only start, stop and timeout errors are flagged.

Decomposition:
- Package keycode_pkg holds:
  - HID constants: KEY_NONE = 8'h00, KEY_SPACE = 8'd44, KEY_ESC = 8'd41, KEY_ENTER, KEY_W/A/S/D, KEY_UP/DOWN/LEFT/RIGHT.
  - PS/2 prefix constants: PS2_EXT = 8'hE0, PS2_BRK = 8'hF0.
  - The framer state enum.
- Sub-module ps2_frame_rx contains the synchronizers, filter, timeout counter and framer FSM, and outputs byte[7:0], byte_valid and frame_err.
- The top level contains the prefix flags, the map lookup and the Keycode register.

Test Plan:
- Frame 0x29, then F0 29 -> Keycode 8'd44 with a key_event pulse; after the break, Keycode 8'h00 with a second key_event pulse.
- Frames 0x76 sent 3 times (typematic) -> Keycode 8'd41 after the first frame and exactly one key_event pulse in total.
- Sequence E0 75, then 1C, then E0 F0 75 -> Keycode 52, then 04, then stays 04 (the break of a non-current key is ignored).
- Frame 0x29 with a flipped parity bit -> with PS2_PARITY_CHECK_EN: frame_err pulses and Keycode stays 00. Without the macro: Keycode becomes 8'd44.
- Start bit plus 4 data bits, then silence for TIMEOUT_CYCLES + 1 -> frame_err pulses once and the framer returns to IDLE. A following valid 0x5A frame -> Keycode 28.
- Reset asserted mid-frame while Keycode = 2C -> Keycode 00 and outputs 0 immediately (asynchronous). After release, a valid 0x1D frame -> Keycode 1A.
